// File: rtl/conduit_arbiter.sv
// Two-master round-robin arbiter for a single register-file conduit.
// One slave transaction is outstanding at a time; a silent slave is answered with a forced error.
module conduit_arbiter #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 12,
    parameter int TIMEOUT = 16
) (
    input  logic                   pclk,
    input  logic                   presetn,
    input  logic                   m0_wr,
    input  logic                   m0_rd,
    input  logic [A_WIDTH-1:0]     m0_waddr,
    input  logic [A_WIDTH-1:0]     m0_raddr,
    input  logic [D_WIDTH-1:0]     m0_wdata,
    input  logic [D_WIDTH/8-1:0]   m0_wbyte_enable,
    output logic                   m0_wr_ack,
    output logic                   m0_read_valid,
    output logic                   m0_slv_error,
    output logic [D_WIDTH-1:0]     m0_rdata,
    input  logic                   m1_wr,
    input  logic                   m1_rd,
    input  logic [A_WIDTH-1:0]     m1_waddr,
    input  logic [A_WIDTH-1:0]     m1_raddr,
    input  logic [D_WIDTH-1:0]     m1_wdata,
    input  logic [D_WIDTH/8-1:0]   m1_wbyte_enable,
    output logic                   m1_wr_ack,
    output logic                   m1_read_valid,
    output logic                   m1_slv_error,
    output logic [D_WIDTH-1:0]     m1_rdata,
    output logic                   s_wr,
    output logic                   s_rd,
    output logic [A_WIDTH-1:0]     s_waddr,
    output logic [A_WIDTH-1:0]     s_raddr,
    output logic [D_WIDTH-1:0]     s_wdata,
    output logic [D_WIDTH/8-1:0]   s_wbyte_enable,
    output logic [D_WIDTH/8-1:0]   s_rbyte_enable,
    output logic                   s_rd_ack,
    input  logic                   s_wr_ack,
    input  logic                   s_read_valid,
    input  logic                   s_slv_error,
    input  logic [D_WIDTH-1:0]     s_rdata,
    output logic [1:0]             overrun
);
    localparam int B_WIDTH = D_WIDTH / 8;
    localparam int T_WIDTH = $clog2(TIMEOUT) + 1;
    localparam logic [T_WIDTH-1:0] T_LAST = T_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2} state_t;

    state_t               r_state;
    logic [1:0]           r_pending;
    logic [1:0]           r_is_wr;
    logic [1:0]           r_overrun;
    logic                 r_owner;
    logic                 r_last;
    logic [T_WIDTH-1:0]   r_timer;
    logic [A_WIDTH-1:0]   r_addr  [2];
    logic [D_WIDTH-1:0]   r_wdata [2];
    logic [B_WIDTH-1:0]   r_be    [2];

    logic [1:0]           w_wr, w_rd, w_req, w_accept, w_drop, w_clear;
    logic [A_WIDTH-1:0]   w_waddr [2];
    logic [A_WIDTH-1:0]   w_raddr [2];
    logic [D_WIDTH-1:0]   w_wdata [2];
    logic [B_WIDTH-1:0]   w_be    [2];
    logic                 w_active, w_own_wr, w_resp, w_forced, w_done;
    logic                 w_err, w_ack, w_rv, w_grant;

    assign w_wr       = {m1_wr, m0_wr};
    assign w_rd       = {m1_rd, m0_rd};
    assign w_waddr[0] = m0_waddr;
    assign w_waddr[1] = m1_waddr;
    assign w_raddr[0] = m0_raddr;
    assign w_raddr[1] = m1_raddr;
    assign w_wdata[0] = m0_wdata;
    assign w_wdata[1] = m1_wdata;
    assign w_be[0]    = m0_wbyte_enable;
    assign w_be[1]    = m1_wbyte_enable;

    // Only the owner's own response type (or an error) ends a transaction.
    assign w_active = (r_state != ST_IDLE);
    assign w_own_wr = r_is_wr[r_owner];
    assign w_resp   = w_active & (s_slv_error | (w_own_wr ? s_wr_ack : s_read_valid));
    assign w_forced = (r_state == ST_WAIT) & (r_timer == T_LAST) & ~w_resp;
    assign w_done   = w_resp | w_forced;
    assign w_err    = w_active & (s_slv_error | w_forced);
    assign w_ack    = w_active & w_own_wr & s_wr_ack & ~s_slv_error;
    assign w_rv     = w_active & ~w_own_wr & s_read_valid & ~s_slv_error;
    assign w_clear  = {w_done & r_owner, w_done & ~r_owner};

    // A requester may re-arm in the very cycle its own transaction completes.
    assign w_req       = w_wr | w_rd;
    assign w_accept[0] = w_req[0] & (~r_pending[0] | w_clear[0]);
    assign w_accept[1] = w_req[1] & (~r_pending[1] | w_clear[1]);
    assign w_drop      = (w_wr & w_rd) | (w_req & ~w_accept);
    assign w_grant     = (&r_pending) ? ~r_last : r_pending[1];

    // Request capture, per-requester field latches and sticky overrun flags
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_pending <= 2'b00;
            r_is_wr   <= 2'b00;
            r_overrun <= 2'b00;
            for (int n = 0; n < 2; n++) begin
                r_addr[n]  <= {A_WIDTH{1'b0}};
                r_wdata[n] <= {D_WIDTH{1'b0}};
                r_be[n]    <= {B_WIDTH{1'b0}};
            end
        end else begin
            r_pending <= (r_pending & ~w_clear) | w_accept;
            r_overrun <= r_overrun | w_drop;
            for (int n = 0; n < 2; n++) begin
                if (w_accept[n]) begin
                    r_is_wr[n] <= w_wr[n];
                    r_addr[n]  <= w_wr[n] ? w_waddr[n] : w_raddr[n];
                    r_wdata[n] <= w_wdata[n];
                    r_be[n]    <= w_be[n];
                end
            end
        end
    end

    // Transaction FSM: grant, one-cycle issue, wait with timeout
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_timer <= {T_WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|r_pending) begin
                        r_owner <= w_grant;
                        r_last  <= w_grant;
                        r_timer <= {T_WIDTH{1'b0}};
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    if (w_done) begin
                        r_timer <= {T_WIDTH{1'b0}};
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + T_WIDTH'(1);
                        r_state <= ST_WAIT;
                    end
                end
                default: begin
                    r_timer <= {T_WIDTH{1'b0}};
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_wr           = (r_state == ST_ISSUE) & w_own_wr;
    assign s_rd           = (r_state == ST_ISSUE) & ~w_own_wr;
    assign s_waddr        = (w_active & w_own_wr)  ? r_addr[r_owner]  : {A_WIDTH{1'b0}};
    assign s_raddr        = (w_active & ~w_own_wr) ? r_addr[r_owner]  : {A_WIDTH{1'b0}};
    assign s_wdata        = (w_active & w_own_wr)  ? r_wdata[r_owner] : {D_WIDTH{1'b0}};
    assign s_wbyte_enable = (w_active & w_own_wr)  ? r_be[r_owner]    : {B_WIDTH{1'b0}};
    assign s_rbyte_enable = {B_WIDTH{1'b1}};
    assign s_rd_ack       = w_active & ~w_own_wr & s_read_valid;
    assign overrun        = r_overrun;

    assign m0_wr_ack     = w_ack & ~r_owner;
    assign m0_read_valid = w_rv  & ~r_owner;
    assign m0_slv_error  = w_err & ~r_owner;
    assign m0_rdata      = (w_rv & ~r_owner) ? s_rdata : {D_WIDTH{1'b0}};
    assign m1_wr_ack     = w_ack & r_owner;
    assign m1_read_valid = w_rv  & r_owner;
    assign m1_slv_error  = w_err & r_owner;
    assign m1_rdata      = (w_rv & r_owner) ? s_rdata : {D_WIDTH{1'b0}};
endmodule
